uart_rx_sipo: RTL and testbench

Serial-in/parallel-out front end of the UART receiver. Synchronises the asynchronous `SerialIn` line and detects a start bit using oversampled baud ticks. Samples each bit at its centre and assembles the 11-bit frame `DataParl`. Pulses `RecievedFlag` so the downstream deframing stage can split the frame into start, data, parity and stop fields.

---
 rtl/uart_rx_pkg.sv | 11 +
 rtl/sync_2ff.sv | 19 +
 rtl/uart_rx_sipo.sv | 108 ++++++++++
 tb/tb_uart_rx_sipo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state type and frame layout constants for the UART receive front end
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, DONE} rx_state_t;

    localparam int FRAME_BITS = 11;
    localparam int START_IDX  = 0;
    localparam int PARITY_IDX = 9;
    localparam int STOP_IDX   = 10;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser, resets to 1 (idle line level)
//   clk in  - destination clock
//   rst in  - asynchronous active-high reset
//   d   in  - asynchronous input
//   q   out - synchronised output, 2 cycles latency
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst)
        if (rst) {q, meta} <= 2'b11;
        else     {q, meta} <= {meta, d};

endmodule

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampled UART receive front end, assembles a full serial frame into DataParl
//   Clock        in  - system clock
//   Reset        in  - asynchronous active-high reset
//   BaudTick     in  - enable pulse at OVERSAMPLE x baud rate
//   SerialIn     in  - raw asynchronous RX line, idle high
//   DataParl     out - last received frame, bit 0 = start, MSB = stop
//   RecievedFlag out - one-cycle pulse when DataParl has been updated
//   Active       out - high while a frame is in progress
module uart_rx_sipo
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FRAME_BITS = uart_rx_pkg::FRAME_BITS
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BaudTick,
    input  logic                  SerialIn,
    output logic [FRAME_BITS-1:0] DataParl,
    output logic                  RecievedFlag,
    output logic                  Active
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(FRAME_BITS);
    localparam logic [TW-1:0] HALF_LAST  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] FRAME_LAST = BW'(FRAME_BITS - 1);

    rx_state_t             state, state_d;
    logic [TW-1:0]         tick_cnt, tick_d;
    logic [BW-1:0]         bit_cnt, bit_d;
    logic [FRAME_BITS-1:0] shreg, shreg_d, data_d;
    logic                  flag_d;
    logic                  rxs;

    sync_2ff u_sync (
        .clk (Clock),
        .rst (Reset),
        .d   (SerialIn),
        .q   (rxs)
    );

    assign Active = (state != IDLE);

    always_comb begin
        state_d = state;
        tick_d  = tick_cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        data_d  = DataParl;
        flag_d  = 1'b0;
        case (state)
            IDLE:
                if (BaudTick && !rxs) begin
                    tick_d  = '0;
                    state_d = START;
                end
            START:
                if (BaudTick) begin
                    tick_d = tick_cnt + 1'b1;
                    if (tick_cnt == HALF_LAST) begin
                        // a start bit that is high again at mid-bit was a glitch
                        state_d = rxs ? IDLE : DATA;
                        if (!rxs) begin
                            shreg_d = {rxs, shreg[FRAME_BITS-1:1]};
                            tick_d  = '0;
                            bit_d   = BW'(1);
                        end
                    end
                end
            DATA:
                if (BaudTick) begin
                    tick_d = tick_cnt + 1'b1;
                    if (tick_cnt == BIT_LAST) begin
                        shreg_d = {rxs, shreg[FRAME_BITS-1:1]};
                        tick_d  = '0;
                        bit_d   = bit_cnt + 1'b1;
                        state_d = (bit_cnt == FRAME_LAST) ? DONE : DATA;
                    end
                end
            DONE: begin
                // publish the frame; DataParl is registered so it is valid with the flag
                data_d  = shreg;
                flag_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shreg        <= '1;
            DataParl     <= '1;
            RecievedFlag <= 1'b0;
        end else begin
            state        <= state_d;
            tick_cnt     <= tick_d;
            bit_cnt      <= bit_d;
            shreg        <= shreg_d;
            DataParl     <= data_d;
            RecievedFlag <= flag_d;
        end

endmodule

// File: tb/tb_uart_rx_sipo.sv
// tb_uart_rx_sipo: scoreboard bench for uart_rx_sipo, frames queued when driven and checked on RecievedFlag
module tb_uart_rx_sipo;
    import uart_rx_pkg::*;

    localparam int OS = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        BaudTick = 1'b0;
    logic        SerialIn = 1'b1;
    logic [10:0] DataParl;
    logic        RecievedFlag;
    logic        Active;

    typedef struct {
        logic [10:0] data;
        int          edge_cyc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   div = 1;
    int   last_flag = -1;
    int   prev_flag_cyc = -1;
    logic prev_flag = 1'b0;

    uart_rx_sipo #(.OVERSAMPLE(OS), .FRAME_BITS(11)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .BaudTick     (BaudTick),
        .SerialIn     (SerialIn),
        .DataParl     (DataParl),
        .RecievedFlag (RecievedFlag),
        .Active       (Active)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic stop);
        return {stop, ^d, d, 1'b0};
    endfunction

    task automatic wait_ticks(input int n);
        repeat (n * div) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic drive_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            SerialIn = f[i];
            wait_ticks(OS);
        end
    endtask

    task automatic send(input logic [10:0] f);
        exp_t e;
        e.data = f;
        e.edge_cyc = cyc;
        e.lat = (div == 1);
        exp_q.push_back(e);
        drive_bits(f, 11);
        SerialIn = 1'b1;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (exp_q.size() != 0 && k < 2000) begin
            @(negedge Clock);
            k++;
        end
        chk(tag, exp_q.size(), 0);
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int t = 0;
        forever begin
            @(posedge Clock);
            #1;
            BaudTick = (t == div - 1);
            t = (t >= div - 1) ? 0 : t + 1;
        end
    end

    initial forever begin
        @(negedge Clock);
        if (!Reset && RecievedFlag) begin
            chk("flag_single", prev_flag, 0);
            if (exp_q.size() == 0) chk("unexpected_flag", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("data", DataParl, mon_e.data);
                if (mon_e.lat) chk("latency", cyc - mon_e.edge_cyc, 172);
            end
            prev_flag_cyc = last_flag;
            last_flag = cyc;
        end
        prev_flag = RecievedFlag;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int fl;
        logic [10:0] f;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_data", DataParl, 11'h7FF);
        chk("rst_flag", RecievedFlag, 0);
        chk("rst_active", Active, 0);
        Reset = 1'b0;
        wait_ticks(5);

        send(mk(8'hA5, 1'b1));
        drain("a5_drain");
        chk("a5_value", DataParl, 11'h54A);
        wait_ticks(20);

        fl = last_flag;
        g = cyc;
        SerialIn = 1'b0;
        wait_ticks(4);
        SerialIn = 1'b1;
        wait_ticks(2);
        chk("glitch_active", Active, 1);
        wait_ticks(6);
        chk("glitch_idle", Active, 0);
        chk("glitch_cyc", cyc - g, 12);
        chk("glitch_hold", DataParl, 11'h54A);
        wait_ticks(30);
        chk("glitch_noflag", last_flag, fl);

        send(mk(8'h3C, 1'b0));
        drain("fe_drain");
        chk("fe_stop", DataParl[STOP_IDX], 0);
        chk("fe_data", DataParl[8:1], 8'h3C);
        chk("fe_parity", DataParl[PARITY_IDX], 0);
        chk("fe_start", DataParl[START_IDX], 0);
        wait_ticks(40);

        send(mk(8'h00, 1'b1));
        send(mk(8'hFF, 1'b1));
        drain("b2b_drain");
        chk("b2b_gap", last_flag - prev_flag_cyc, 176);
        chk("b2b_data", DataParl, 11'h5FE);
        wait_ticks(20);

        div = 3;
        wait_ticks(4);
        send(mk(8'h5A, 1'b1));
        drain("slow_drain");
        chk("slow_data", DataParl[8:1], 8'h5A);
        div = 1;
        wait_ticks(10);

        f = mk(8'h66, 1'b1);
        drive_bits(f, 5);
        SerialIn = f[5];
        wait_ticks(8);
        chk("abort_active_pre", Active, 1);
        fl = last_flag;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("abort_active", Active, 0);
        chk("abort_data", DataParl, 11'h7FF);
        SerialIn = 1'b1;
        Reset = 1'b0;
        wait_ticks(40);
        chk("abort_noflag", last_flag, fl);
        send(mk(8'h81, 1'b1));
        drain("rec_drain");
        chk("rec_data", DataParl[8:1], 8'h81);
        wait_ticks(10);

        Reset = 1'b1;
        @(posedge Clock);
        #1;
        chk("idle_rst_data", DataParl, 11'h7FF);
        chk("idle_rst_flag", RecievedFlag, 0);
        chk("idle_rst_active", Active, 0);
        Reset = 1'b0;
        wait_ticks(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
